// File: rtl/uart_tx_arbiter_if.sv
// Requester and transmitter side signals of the UART transmit arbiter.
// The master modport is the arbiter. The slave modport is the producers and transmitter.
interface uart_tx_arbiter_if #(
  parameter int NUM_REQ   = 4,
  parameter int DATA_BITS = 8
);
  localparam int GW = $clog2(NUM_REQ);

  logic [NUM_REQ-1:0]           Req_Valid;
  logic [NUM_REQ*DATA_BITS-1:0] Req_Data;
  logic [NUM_REQ-1:0]           Req_Ack;
  logic                         CTS;
  logic                         Tx_Busy;
  logic                         Tx_Start;
  logic [DATA_BITS-1:0]         Tx_Data;
  logic [GW-1:0]                Grant_Id;
  logic                         Arb_Busy;
  logic                         Tx_Error;

  modport master (
    input  Req_Valid, Req_Data, CTS, Tx_Busy,
    output Req_Ack, Tx_Start, Tx_Data, Grant_Id, Arb_Busy, Tx_Error
  );

  modport slave (
    output Req_Valid, Req_Data, CTS, Tx_Busy,
    input  Req_Ack, Tx_Start, Tx_Data, Grant_Id, Arb_Busy, Tx_Error
  );
endinterface

// File: rtl/uart_tx_arbiter.sv
// Round-robin scheduler sharing one UART transmitter among NUM_REQ byte producers.
// It supports bursts, CTS gating and a start-acknowledge timeout.
//
// state     | meaning
// IDLE      | nothing pending or CTS low
// ARB       | round-robin pick from last_grant+1
// LOAD      | launch byte: Tx_Start/Req_Ack pulse
// WAIT_BUSY | waiting for transmitter to raise Tx_Busy
// WAIT_DONE | byte in flight, waiting for Tx_Busy to fall
module uart_tx_arbiter #(
  parameter int NUM_REQ       = 4,
  parameter int DATA_BITS     = 8,
  parameter int MAX_BURST     = 4,
  parameter int START_TIMEOUT = 15
) (
  input  logic              Clk,
  input  logic              Rst,
  uart_tx_arbiter_if.master bus
);
  localparam int GW  = $clog2(NUM_REQ);
  localparam int BW  = $clog2(MAX_BURST + 1);
  localparam int BW1 = BW + 1;
  localparam int TW  = $clog2(START_TIMEOUT + 1);
  localparam logic [BW:0]   MAX_B   = BW1'(MAX_BURST);
  localparam logic [TW-1:0] TO_LAST = TW'(START_TIMEOUT - 1);

  typedef enum logic [2:0] {IDLE, ARB, LOAD, WAIT_BUSY, WAIT_DONE} state_t;

  state_t               state, state_n;
  logic [GW-1:0]        grant, grant_n, last_grant, last_n;
  logic [BW-1:0]        burst_cnt, burst_n;
  logic [BW:0]          burst_inc;
  logic [TW-1:0]        timeout, timeout_n;
  logic [DATA_BITS-1:0] tx_data, data_n;
  logic                 tx_start, start_n, tx_error, error_n;
  logic [NUM_REQ-1:0]   req_ack, ack_n;
  logic                 found;
  logic [GW-1:0]        win, idx_g;
  int                   idx;

  assign burst_inc = {1'b0, burst_cnt} + {{BW{1'b0}}, 1'b1};

  always_comb begin
    found = 1'b0;
    win   = last_grant;
    idx   = 0;
    idx_g = '0;
    for (int i = 1; i <= NUM_REQ; i++) begin
      idx   = (int'(last_grant) + i) % NUM_REQ;
      idx_g = GW'(idx);
      if (!found && bus.Req_Valid[idx_g]) begin
        found = 1'b1;
        win   = idx_g;
      end
    end
  end

  always_comb begin
    state_n   = state;
    grant_n   = grant;
    last_n    = last_grant;
    burst_n   = burst_cnt;
    timeout_n = timeout;
    data_n    = tx_data;
    start_n   = 1'b0;
    ack_n     = '0;
    error_n   = 1'b0;
    case (state)
      IDLE: if (|bus.Req_Valid && bus.CTS) state_n = ARB;
      ARB: begin
        if (found) begin
          grant_n = win;
          burst_n = '0;
          state_n = LOAD;
        end else begin
          state_n = IDLE;
        end
      end
      LOAD: begin
        timeout_n = '0;
        if (tx_start) begin
          state_n = WAIT_BUSY;
        end else begin
          last_n  = grant;
          state_n = IDLE;
        end
      end
      WAIT_BUSY: begin
        if (bus.Tx_Busy) begin
          state_n = WAIT_DONE;
        end else if (timeout == TO_LAST) begin
          error_n = 1'b1;
          last_n  = grant;
          state_n = IDLE;
        end else begin
          timeout_n = timeout + 1'b1;
        end
      end
      WAIT_DONE: begin
        if (!bus.Tx_Busy) begin
          burst_n = burst_inc[BW-1:0];
          if (burst_inc < MAX_B && bus.Req_Valid[grant] && bus.CTS) begin
            state_n = LOAD;
          end else begin
            last_n  = grant;
            state_n = (|bus.Req_Valid && bus.CTS) ? ARB : IDLE;
          end
        end
      end
      default: state_n = IDLE;
    endcase
    // Launch decision is taken on entry so Tx_Start/Req_Ack are registered in LOAD
    if (state_n == LOAD && bus.Req_Valid[grant_n]) begin
      start_n        = 1'b1;
      ack_n[grant_n] = 1'b1;
      data_n         = bus.Req_Data[grant_n*DATA_BITS +: DATA_BITS];
    end
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      state      <= IDLE;
      grant      <= '0;
      last_grant <= GW'(NUM_REQ - 1);
      burst_cnt  <= '0;
      timeout    <= '0;
      tx_data    <= '0;
      tx_start   <= 1'b0;
      req_ack    <= '0;
      tx_error   <= 1'b0;
    end else begin
      state      <= state_n;
      grant      <= grant_n;
      last_grant <= last_n;
      burst_cnt  <= burst_n;
      timeout    <= timeout_n;
      tx_data    <= data_n;
      tx_start   <= start_n;
      req_ack    <= ack_n;
      tx_error   <= error_n;
    end
  end

  assign bus.Req_Ack  = req_ack;
  assign bus.Tx_Start = tx_start;
  assign bus.Tx_Data  = tx_data;
  assign bus.Grant_Id = grant;
  assign bus.Arb_Busy = (state != IDLE);
  assign bus.Tx_Error = tx_error;
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter.
// A transmitter busy model and the requester byte queues are advanced once per clock in tick().
module tb_uart_tx_arbiter;
  logic Clk, Rst;
  int total = 0, bad = 0;
  int rem [4];
  logic [7:0] nxt [4];
  int busy_left = 0, busy_len = 3;
  bit tx_model_en = 1'b1;
  int sent [4];
  int gseq [5];
  int cnt3;

  uart_tx_arbiter_if #(.NUM_REQ(4), .DATA_BITS(8)) bus ();

  uart_tx_arbiter #(
    .NUM_REQ(4), .DATA_BITS(8), .MAX_BURST(4), .START_TIMEOUT(15)
  ) dut (
    .Clk(Clk),
    .Rst(Rst),
    .bus(bus)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_req(input int i, input int n, input logic [7:0] d);
    rem[i] = n;
    nxt[i] = d;
    bus.Req_Valid[i] = (n > 0);
    bus.Req_Data[i*8 +: 8] = d;
  endtask

  // One clock: sample 1ns after the edge, then advance the transmitter and requester models
  task automatic tick();
    @(posedge Clk);
    #1;
    chk("ack_onehot", 64'($onehot0(bus.Req_Ack)), 64'd1);
    chk("ack_start_coincide", 64'(bus.Tx_Start), 64'(|bus.Req_Ack));
    if (tx_model_en) begin
      if (bus.Tx_Start) busy_left = busy_len;
      else if (busy_left > 0) busy_left--;
      bus.Tx_Busy = (busy_left > 0);
    end
    for (int i = 0; i < 4; i++) begin
      if (bus.Req_Ack[i] && rem[i] > 0) begin
        rem[i]--;
        nxt[i] = nxt[i] + 8'd1;
      end
      bus.Req_Valid[i] = (rem[i] > 0);
      bus.Req_Data[i*8 +: 8] = nxt[i];
    end
  endtask

  task automatic chk_start(input string tag, input int exp_wait, input int g, input logic [7:0] d);
    int w;
    w = 0;
    do begin
      tick();
      w++;
    end while (!bus.Tx_Start && w < 40);
    chk({tag, "_latency"}, 64'(w), 64'(exp_wait));
    chk({tag, "_grant"}, 64'(bus.Grant_Id), 64'(g));
    chk({tag, "_ack"}, 64'(bus.Req_Ack), 64'(4'b0001 << g));
    chk({tag, "_data"}, 64'(bus.Tx_Data), 64'(d));
  endtask

  initial begin
    Rst = 1'b1;
    bus.CTS = 1'b1;
    bus.Tx_Busy = 1'b0;
    bus.Req_Valid = '0;
    bus.Req_Data = '0;
    for (int i = 0; i < 4; i++) begin
      rem[i] = 0;
      nxt[i] = 8'h00;
      sent[i] = 0;
    end
    gseq = '{0, 1, 2, 3, 0};

    // reset values
    tick();
    tick();
    chk("rst_start", 64'(bus.Tx_Start), 64'd0);
    chk("rst_ack", 64'(bus.Req_Ack), 64'd0);
    chk("rst_data", 64'(bus.Tx_Data), 64'd0);
    chk("rst_grant", 64'(bus.Grant_Id), 64'd0);
    chk("rst_arb_busy", 64'(bus.Arb_Busy), 64'd0);
    chk("rst_error", 64'(bus.Tx_Error), 64'd0);
    Rst = 1'b0;

    // single requester, 10-cycle busy
    busy_len = 10;
    set_req(0, 1, 8'hA5);
    chk_start("single", 2, 0, 8'hA5);
    tick();
    chk("single_pulse_width", 64'(bus.Tx_Start), 64'd0);
    for (int i = 0; i < 8; i++) tick();
    tick();
    chk("single_busy_before_fall", 64'(bus.Arb_Busy), 64'd1);
    tick();
    chk("single_idle_after_fall", 64'(bus.Arb_Busy), 64'd0);
    chk("single_data_stable", 64'(bus.Tx_Data), 64'hA5);

    // fairness from reset: 0,1,2,3,0 with 4 bytes each
    Rst = 1'b1;
    tick();
    Rst = 1'b0;
    busy_len = 3;
    for (int i = 0; i < 4; i++) set_req(i, 100, 8'(i * 16));
    for (int k = 0; k < 5; k++) begin
      for (int b = 0; b < 4; b++) begin
        chk_start("fair", (k == 0 && b == 0) ? 2 : (b == 0 ? 5 : 4),
                  gseq[k], 8'(gseq[k] * 16 + sent[gseq[k]]));
        sent[gseq[k]]++;
      end
    end
    for (int i = 0; i < 4; i++) set_req(i, 0, 8'h00);
    for (int i = 0; i < 8; i++) tick();
    chk("fair_drained", 64'(bus.Arb_Busy), 64'd0);

    // burst cut short: 2 stops after 2 bytes, 3 follows at fall+2
    set_req(2, 2, 8'h40);
    set_req(3, 1, 8'h50);
    chk_start("cut_b0", 2, 2, 8'h40);
    chk_start("cut_b1", 4, 2, 8'h41);
    chk_start("cut_next", 5, 3, 8'h50);
    for (int i = 0; i < 8; i++) tick();
    chk("cut_drained", 64'(bus.Arb_Busy), 64'd0);

    // CTS drop during WAIT_DONE of the first byte
    set_req(0, 3, 8'h60);
    chk_start("cts_b0", 2, 0, 8'h60);
    tick();
    tick();
    bus.CTS = 1'b0;
    chk("cts_inflight", 64'(bus.Arb_Busy), 64'd1);
    tick();
    chk("cts_completes", 64'(bus.Arb_Busy), 64'd1);
    tick();
    chk("cts_idle", 64'(bus.Arb_Busy), 64'd0);
    for (int i = 0; i < 6; i++) begin
      tick();
      chk("cts_hold_start", 64'(bus.Tx_Start), 64'd0);
    end
    bus.CTS = 1'b1;
    chk_start("cts_resume", 2, 0, 8'h61);
    chk_start("cts_b2", 4, 0, 8'h62);
    for (int i = 0; i < 8; i++) tick();
    chk("cts_drained", 64'(bus.Arb_Busy), 64'd0);

    // start timeout with Tx_Busy stuck low
    tx_model_en = 1'b0;
    busy_left = 0;
    bus.Tx_Busy = 1'b0;
    set_req(1, 1, 8'h70);
    set_req(2, 1, 8'h80);
    chk_start("to_start", 2, 1, 8'h70);
    for (int i = 0; i < 15; i++) begin
      tick();
      chk("to_no_early_error", 64'(bus.Tx_Error), 64'd0);
    end
    tick();
    chk("to_error_pulse", 64'(bus.Tx_Error), 64'd1);
    chk("to_back_idle", 64'(bus.Arb_Busy), 64'd0);
    tick();
    chk("to_error_one_cycle", 64'(bus.Tx_Error), 64'd0);
    chk("to_rearb", 64'(bus.Arb_Busy), 64'd1);
    tx_model_en = 1'b1;
    tick();
    chk("to_next_start", 64'(bus.Tx_Start), 64'd1);
    chk("to_next_grant", 64'(bus.Grant_Id), 64'd2);
    chk("to_next_data", 64'(bus.Tx_Data), 64'h80);
    for (int i = 0; i < 8; i++) tick();
    chk("to_drained", 64'(bus.Arb_Busy), 64'd0);

    // reset mid-burst while WAIT_DONE
    set_req(3, 4, 8'h90);
    chk_start("rb_start", 2, 3, 8'h90);
    tick();
    tick();
    Rst = 1'b1;
    set_req(0, 1, 8'hA0);
    tick();
    chk("rb_start_zero", 64'(bus.Tx_Start), 64'd0);
    chk("rb_ack_zero", 64'(bus.Req_Ack), 64'd0);
    chk("rb_data_zero", 64'(bus.Tx_Data), 64'd0);
    chk("rb_grant_zero", 64'(bus.Grant_Id), 64'd0);
    chk("rb_arb_busy_zero", 64'(bus.Arb_Busy), 64'd0);
    chk("rb_error_zero", 64'(bus.Tx_Error), 64'd0);
    Rst = 1'b0;
    chk_start("rb_first", 2, 0, 8'hA0);
    cnt3 = 0;
    for (int i = 0; i < 60; i++) begin
      tick();
      if (bus.Req_Ack[3]) cnt3++;
    end
    chk("rb_req3_bytes", 64'(cnt3), 64'd3);
    chk("rb_drained", 64'(bus.Arb_Busy), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
